// File: rtl/axi_wr_burst_arbiter.sv
// Round-robin AXI write-channel arbiter: one master owns AW, W and B for a whole burst.
// Only handshake/steering is produced here; grant_idx selects the external payload muxes.
module axi_wr_burst_arbiter #(
  parameter int NUM_MST = 2,
  parameter int LEN_W   = 8,
  parameter int IDX_W   = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_MST-1:0]       m_awvalid,
  input  logic [NUM_MST*LEN_W-1:0] m_awlen,
  output logic [NUM_MST-1:0]       m_awready,
  input  logic [NUM_MST-1:0]       m_wvalid,
  input  logic [NUM_MST-1:0]       m_wlast,
  output logic [NUM_MST-1:0]       m_wready,
  output logic [NUM_MST-1:0]       m_bvalid,
  input  logic [NUM_MST-1:0]       m_bready,
  output logic                     s_awvalid,
  input  logic                     s_awready,
  output logic                     s_wvalid,
  output logic                     s_wlast,
  input  logic                     s_wready,
  input  logic                     s_bvalid,
  output logic                     s_bready,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     busy,
  output logic                     len_err
);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_grant;
  logic [LEN_W:0]   r_beat_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_len_err;
  logic             r_err_seen;

  logic [LEN_W-1:0] w_len_arr [NUM_MST];
  logic [IDX_W-1:0] w_pick;
  logic             w_any;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_b_hs;
  logic             w_at_len;

  for (genvar g = 0; g < NUM_MST; g++) begin : g_len
    assign w_len_arr[g] = m_awlen[g*LEN_W +: LEN_W];
  end

  // Search starts at the round-robin pointer and wraps back to master 0.
  always_comb begin
    int j;
    j      = 0;
    w_any  = 1'b0;
    w_pick = r_ptr;
    for (int k = 0; k < NUM_MST; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NUM_MST) j = j - NUM_MST;
      if (!w_any && m_awvalid[j[IDX_W-1:0]]) begin
        w_any  = 1'b1;
        w_pick = j[IDX_W-1:0];
      end
    end
  end

  // Steering is gated by state so an asynchronous reset silences every handshake at once.
  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_wlast   = 1'b0;
    s_bready  = 1'b0;
    case (r_state)
      S_AW: begin
        s_awvalid          = m_awvalid[r_grant];
        m_awready[r_grant] = s_awready;
      end
      S_W: begin
        s_wvalid          = m_wvalid[r_grant];
        s_wlast           = m_wlast[r_grant];
        m_wready[r_grant] = s_wready;
      end
      S_B: begin
        m_bvalid[r_grant] = s_bvalid;
        s_bready          = m_bready[r_grant];
      end
      default: ;
    endcase
  end

  assign w_aw_hs  = s_awvalid & s_awready;
  assign w_w_hs   = s_wvalid & s_wready;
  assign w_b_hs   = s_bvalid & s_bready;
  assign w_at_len = (r_beat_cnt == {1'b0, r_len});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_beat_cnt <= '0;
      r_len      <= '0;
      r_len_err  <= 1'b0;
      r_err_seen <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_len   <= w_len_arr[w_pick];
            r_state <= S_AW;
          end
        end
        S_AW: begin
          if (w_aw_hs) begin
            r_beat_cnt <= '0;
            r_err_seen <= 1'b0;
            r_state    <= S_W;
          end
        end
        S_W: begin
          if (w_w_hs) begin
            if (r_beat_cnt != '1) r_beat_cnt <= r_beat_cnt + 1'b1;
            // r_beat_cnt counts beats before this one, so the final beat sits at r_len.
            if (s_wlast) begin
              r_state <= S_B;
              if (!w_at_len && !r_err_seen) begin
                r_len_err  <= 1'b1;
                r_err_seen <= 1'b1;
              end
            end else if (w_at_len && !r_err_seen) begin
              r_len_err  <= 1'b1;
              r_err_seen <= 1'b1;
            end
          end
        end
        S_B: begin
          if (w_b_hs) begin
            if (r_grant == IDX_W'(NUM_MST - 1)) r_ptr <= '0;
            else                                r_ptr <= r_grant + IDX_W'(1);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant_idx = r_grant;
  assign busy      = (r_state != S_IDLE);
  assign len_err   = r_len_err;

endmodule
